// File: rtl/gnr_node_array_pkg.sv
// ----------------------------------------------------------------------------
// gnr_pkg: shared constants and helpers for the gene-node array.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gnr_pkg;

  localparam int GNR_LUT_IDX_MAX = 6;

  function automatic int gnr_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Saturating increment; callers truncate the result to their counter width.
  function automatic logic [31:0] gnr_sat_inc(input logic [31:0] cnt, input logic [31:0] max_v);
    return (cnt >= max_v) ? max_v : cnt + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gnr_node_array_if.sv
// ----------------------------------------------------------------------------
// gnr_node_array_if: control, regulator and state bundle of the gene-node array.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface gnr_node_array_if #(
  parameter int NUM_CH = 2,
  parameter int K      = 2
);
  logic                  reset_nos;
  logic                  hold_mode;
  logic [(2**K)-1:0]     lut;
  logic [NUM_CH-1:0]     init_state;
  logic [NUM_CH-1:0]     start_s;
  logic [NUM_CH*K-1:0]   regs_in;
  logic [NUM_CH-1:0]     s;
  logic [NUM_CH-1:0]     galphas_s;
  logic [NUM_CH-1:0]     stable;

  modport master (
    output reset_nos, hold_mode, lut, init_state, start_s, regs_in,
    input  s, galphas_s, stable
  );

  modport slave (
    input  reset_nos, hold_mode, lut, init_state, start_s, regs_in,
    output s, galphas_s, stable
  );
endinterface

`default_nettype wire

// File: rtl/gnr_node_array_ch.sv
// ----------------------------------------------------------------------------
// gnr_node_ch: one boolean gene-node channel with update divider and stability flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gnr_node_ch
  import gnr_pkg::*;
#(
  parameter int K          = 2,
  parameter int DIV        = 2,
  parameter int STABLE_THR = 4,
  parameter int STAB_W     = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              reset_nos_i,
  input  wire logic              hold_mode_i,
  input  wire logic [(2**K)-1:0] lut_i,
  input  wire logic              init_i,
  input  wire logic              start_i,
  input  wire logic [K-1:0]      regs_i,
  output logic                   s_o,
  output logic                   stable_o
);

  localparam int                PH_W      = (DIV > 1) ? gnr_clog2(DIV) : 1;
  localparam logic [PH_W-1:0]   PH_RELOAD = PH_W'(DIV - 1);
  localparam logic [31:0]       CNT_MAX   = 32'((1 << STAB_W) - 1);
  localparam logic [STAB_W-1:0] THR       = STAB_W'(STABLE_THR);

  logic              s_q;
  logic              stable_q;
  logic [PH_W-1:0]   phase_q;
  logic [STAB_W-1:0] cnt_q;
  logic              s_d;
  logic [STAB_W-1:0] cnt_d;

  always_comb begin
    s_d   = hold_mode_i ? s_q : lut_i[regs_i];
    cnt_d = '0;
    if (s_d == s_q) cnt_d = STAB_W'(gnr_sat_inc(32'(cnt_q), CNT_MAX));
  end

  // After rst the divider is preloaded so the first start is skipped;
  // after reset_nos it is cleared so the first start updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q      <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      phase_q  <= PH_RELOAD;
    end else if (reset_nos_i) begin
      s_q      <= init_i;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      phase_q  <= '0;
    end else if (start_i) begin
      if (phase_q == '0) begin
        s_q      <= s_d;
        cnt_q    <= cnt_d;
        stable_q <= (cnt_d >= THR);
        phase_q  <= PH_RELOAD;
      end else begin
        phase_q  <= phase_q - PH_W'(1);
      end
    end
  end

  assign s_o      = s_q;
  assign stable_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/gnr_node_array.sv
// ----------------------------------------------------------------------------
// gnr_node_array: NUM_CH independent gene-node channels sharing one truth table.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gnr_node_array
  import gnr_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int K          = 2,
  parameter int DIV        = 2,
  parameter int STABLE_THR = 4,
  parameter int STAB_W     = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  gnr_node_array_if.slave  bus
);

  logic [NUM_CH-1:0] s_w;
  logic [NUM_CH-1:0] stable_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gnr_node_ch #(
      .K          (K),
      .DIV        (DIV),
      .STABLE_THR (STABLE_THR),
      .STAB_W     (STAB_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .reset_nos_i (bus.reset_nos),
      .hold_mode_i (bus.hold_mode),
      .lut_i       (bus.lut),
      .init_i      (bus.init_state[c]),
      .start_i     (bus.start_s[c]),
      .regs_i      (bus.regs_in[c*K +: K]),
      .s_o         (s_w[c]),
      .stable_o    (stable_w[c])
    );
  end

  assign bus.s         = s_w;
  assign bus.galphas_s = s_w;
  assign bus.stable    = stable_w;

endmodule

`default_nettype wire

// File: tb/tb_gnr_node_array.sv
// ----------------------------------------------------------------------------
// tb_gnr_node_array: three array configurations against a start-counting model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gnr_node_array;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // d=0: K=2 DIV=2, d=1: K=2 DIV=3, d=2: K=1 DIV=1
  int divs[3] = '{2, 3, 1};
  int ks[3]   = '{2, 2, 1};

  logic       rnos[3];
  logic       hold[3];
  logic [3:0] lut[3];
  logic [1:0] init[3];
  logic [1:0] start[3];
  logic [3:0] regs[3];
  logic [1:0] s_obs[3];
  logic [1:0] ga_obs[3];
  logic [1:0] st_obs[3];

  gnr_node_array_if #(.NUM_CH(2), .K(2)) if_a ();
  gnr_node_array_if #(.NUM_CH(2), .K(2)) if_b ();
  gnr_node_array_if #(.NUM_CH(2), .K(1)) if_c ();

  gnr_node_array #(.NUM_CH(2), .K(2), .DIV(2), .STABLE_THR(4), .STAB_W(4))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  gnr_node_array #(.NUM_CH(2), .K(2), .DIV(3), .STABLE_THR(4), .STAB_W(4))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  gnr_node_array #(.NUM_CH(2), .K(1), .DIV(1), .STABLE_THR(4), .STAB_W(4))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.reset_nos = rnos[0];  assign if_a.hold_mode = hold[0];
  assign if_a.lut = lut[0];         assign if_a.init_state = init[0];
  assign if_a.start_s = start[0];   assign if_a.regs_in = regs[0];
  assign if_b.reset_nos = rnos[1];  assign if_b.hold_mode = hold[1];
  assign if_b.lut = lut[1];         assign if_b.init_state = init[1];
  assign if_b.start_s = start[1];   assign if_b.regs_in = regs[1];
  assign if_c.reset_nos = rnos[2];  assign if_c.hold_mode = hold[2];
  assign if_c.lut = lut[2][1:0];    assign if_c.init_state = init[2];
  assign if_c.start_s = start[2];   assign if_c.regs_in = regs[2][1:0];

  assign s_obs[0] = if_a.s;  assign ga_obs[0] = if_a.galphas_s;  assign st_obs[0] = if_a.stable;
  assign s_obs[1] = if_b.s;  assign ga_obs[1] = if_b.galphas_s;  assign st_obs[1] = if_b.stable;
  assign s_obs[2] = if_c.s;  assign ga_obs[2] = if_c.galphas_s;  assign st_obs[2] = if_c.stable;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model: count starts since the last reload; updates land on every DIV-th one,
  // with the first start after reset_nos counting as an update and after rst not.
  int m_s[3][2];
  int m_n[3][2];
  int m_off[3][2];
  int m_run[3][2];

  task automatic model_update();
    int idx;
    int nxt;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (!rst) begin
          m_s[d][c] = 0; m_n[d][c] = 0; m_off[d][c] = 0; m_run[d][c] = 0;
        end else if (rnos[d]) begin
          m_s[d][c] = int'(init[d][c]); m_n[d][c] = 0; m_off[d][c] = 1; m_run[d][c] = 0;
        end else if (start[d][c]) begin
          m_n[d][c]++;
          if (((m_n[d][c] - m_off[d][c]) % divs[d]) == 0) begin
            idx = (int'(regs[d]) >> (c * ks[d])) & ((1 << ks[d]) - 1);
            nxt = hold[d] ? m_s[d][c] : int'(lut[d][idx]);
            if (nxt == m_s[d][c]) m_run[d][c] = (m_run[d][c] >= 15) ? 15 : m_run[d][c] + 1;
            else m_run[d][c] = 0;
            m_s[d][c] = nxt;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        chk_val($sformatf("d%0d_s%0d", d, c), 32'(s_obs[d][c]), 32'(m_s[d][c]));
        chk_val($sformatf("d%0d_galphas%0d", d, c), 32'(ga_obs[d][c]), 32'(m_s[d][c]));
        chk_val($sformatf("d%0d_stable%0d", d, c), 32'(st_obs[d][c]), 32'(m_run[d][c] >= 4));
      end
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      rnos[d] = 1'b0; hold[d] = 1'b0; lut[d] = 4'h0;
      init[d] = 2'b00; start[d] = 2'b00; regs[d] = 4'h0;
    end
  endtask

  int exp3[7] = '{1, 1, 1, 0, 0, 0, 1};

  initial begin
    idle_all();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        m_s[d][c] = 0; m_n[d][c] = 0; m_off[d][c] = 0; m_run[d][c] = 0;
      end

    // Reset, then DIV=2 skips the first start after rst
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    for (int d = 0; d < 3; d++) begin
      chk_val("t1_reset_s", 32'(s_obs[d]), 32'd0);
      chk_val("t1_reset_stable", 32'(st_obs[d]), 32'd0);
    end
    lut[0] = 4'hF; start[0] = 2'b01;
    step();
    chk_val("t1_first_start_skipped", 32'(s_obs[0][0]), 32'd0);
    step();
    chk_val("t1_second_start_updates", 32'(s_obs[0][0]), 32'd1);
    idle_all();

    // AND node after reset_nos: first start updates
    rnos[0] = 1'b1; init[0] = 2'b00;
    step();
    rnos[0] = 1'b0; lut[0] = 4'b1000; regs[0] = 4'b0111; start[0] = 2'b11;
    step();
    chk_val("t2_and", 32'(s_obs[0]), 32'd1);
    idle_all();

    // DIV=3: updates on starts 1, 4 and 7 with a NOT-style table
    rnos[1] = 1'b1;
    step();
    rnos[1] = 1'b0; lut[1] = 4'b0001; start[1] = 2'b01;
    for (int i = 0; i < 7; i++) begin
      regs[1] = 4'(m_s[1][0] & 1);
      step();
      chk_val($sformatf("t3_start%0d", i + 1), 32'(s_obs[1][0]), 32'(exp3[i]));
    end
    idle_all();

    // Identity node: stable after 4 updates, saturates instead of wrapping
    rnos[2] = 1'b1;
    step();
    rnos[2] = 1'b0; hold[2] = 1'b1; start[2] = 2'b01;
    for (int i = 1; i <= 24; i++) begin
      step();
      chk_val($sformatf("t4_stable_%0d", i), 32'(st_obs[2][0]), 32'(i >= 4));
    end
    idle_all();

    // NOT node fed back on itself never stabilises
    rnos[2] = 1'b1;
    step();
    rnos[2] = 1'b0; lut[2] = 4'b0001; start[2] = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      regs[2] = 4'((m_s[2][1] & 1) << 1);
      step();
      chk_val("t5_toggle", 32'(s_obs[2][1]), 32'(i % 2));
      chk_val("t5_never_stable", 32'(st_obs[2][1]), 32'd0);
    end
    idle_all();

    // reload beats start; rst beats both
    start[0] = 2'b11; lut[0] = 4'hF;
    step();
    rnos[0] = 1'b1; init[0] = 2'b10; start[0] = 2'b10;
    step();
    chk_val("t6_reload_wins", 32'(s_obs[0]), 32'd2);
    chk_val("t6_reload_stable", 32'(st_obs[0]), 32'd0);
    rst = 1'b0; start[0] = 2'b11; init[0] = 2'b11;
    step();
    chk_val("t6_rst_wins", 32'(s_obs[0]), 32'd0);
    chk_val("t6_rst_stable", 32'(st_obs[0]), 32'd0);
    rst = 1'b1;
    idle_all();
    step();

    // Randomised traffic on all three configurations
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      for (int d = 0; d < 3; d++) begin
        rnos[d]  = ($urandom_range(0, 29) == 0);
        hold[d]  = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) lut[d] = 4'($urandom);
        init[d]  = 2'($urandom);
        start[d] = 2'($urandom);
        regs[d]  = 4'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
